control_unit_fsm: RTL and testbench

//  Control unit that drives the single-cycle datapath: decodes opcode/z and returns every datapath control strobe.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/control_unit_fsm_decoder.sv | 71 +++++++
 rtl/control_unit_fsm.sv | 108 ++++++++++
 tb/tb_control_unit_fsm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcode map, instruction classes,
// write-data source selects, FSM state encoding and the control-strobe bundle.
package cpu_pkg;

  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_JAL  = 6'b110011;
  localparam logic [5:0] OP_RET  = 6'b110100;
  localparam logic [5:0] OP_IN   = 6'b110101;
  localparam logic [5:0] OP_OUT  = 6'b110110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic       CLS_ALU  = 1'b0;
  localparam logic [1:0] CLS_LI   = 2'b10;
  localparam logic [1:0] CLS_CTRL = 2'b11;

  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_PORT  = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  typedef struct packed {
    logic       s_inc;
    logic       s_if_return;
    logic       we3;
    logic       wez;
    logic       s_we_port;
    logic       s_we_stack;
    logic       s_jalret;
    logic [2:0] op_alu;
    logic [1:0] sel_inputs;
  } ctrl_t;

  // Quiet bundle: sequential fetch, nothing written.
  localparam ctrl_t CTRL_IDLE = '{
    s_inc:       1'b1,
    s_if_return: 1'b0,
    we3:         1'b0,
    wez:         1'b0,
    s_we_port:   1'b0,
    s_we_stack:  1'b0,
    s_jalret:    1'b0,
    op_alu:      3'b000,
    sel_inputs:  SEL_ALU
  };

endpackage

// File: rtl/control_unit_fsm_decoder.sv
// Pure combinational opcode/z decode into datapath strobes, plus flags telling
// the FSM whether the instruction redirects the PC or halts the core.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       taken,
  output logic       is_halt
);

  // Decode opcode into strobes; unlisted control codes fall through as NOP.
  always_comb begin
    ctrl    = CTRL_IDLE;
    taken   = 1'b0;
    is_halt = 1'b0;
    if (opcode[5] == CLS_ALU) begin
      ctrl.op_alu     = opcode[4:2];
      ctrl.we3        = 1'b1;
      ctrl.wez        = 1'b1;
      ctrl.sel_inputs = SEL_ALU;
    end else if (opcode[5:4] == CLS_LI) begin
      ctrl.we3        = 1'b1;
      ctrl.sel_inputs = SEL_IMM;
    end else begin
      case (opcode)
        OP_J: begin
          ctrl.s_inc = 1'b0;
          taken      = 1'b1;
        end
        OP_JZ: begin
          ctrl.s_inc = ~z;
          taken      = z;
        end
        OP_JNZ: begin
          ctrl.s_inc = z;
          taken      = ~z;
        end
        OP_JAL: begin
          ctrl.s_inc      = 1'b0;
          ctrl.s_we_stack = 1'b1;
          ctrl.s_jalret   = 1'b1;
          taken           = 1'b1;
        end
        OP_RET: begin
          ctrl.s_inc       = 1'b0;
          ctrl.s_if_return = 1'b1;
          ctrl.s_we_stack  = 1'b1;
          ctrl.s_jalret    = 1'b0;
          taken            = 1'b1;
        end
        OP_IN: begin
          ctrl.we3        = 1'b1;
          ctrl.sel_inputs = SEL_PORT;
        end
        OP_OUT: begin
          ctrl.s_we_port = 1'b1;
        end
        OP_HALT: begin
          ctrl.s_inc = 1'b0;
          is_halt    = 1'b1;
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Control unit: gates decoded strobes through a BOOT/EXEC/FLUSH/HALT FSM that
// hides the registered program-memory read, and counts retired instructions.
module control_unit_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             resume,
  output logic             s_inc,
  output logic             s_if_return,
  output logic             we3,
  output logic             wez,
  output logic             s_we_port,
  output logic             s_we_stack,
  output logic             s_jalret,
  output logic [2:0]       op_alu,
  output logic [1:0]       sel_inputs,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     state_next;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;
  logic       dec_taken;
  logic       dec_halt;

  opcode_decoder u_dec (
    .opcode  (opcode),
    .z       (z),
    .ctrl    (dec_ctrl),
    .taken   (dec_taken),
    .is_halt (dec_halt)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and strobe gating; only EXEC lets the decoder reach the datapath.
  always_comb begin
    state_next = state;
    ctrl       = CTRL_IDLE;
    halted     = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        ctrl = dec_ctrl;
        if (dec_halt) begin
          state_next = ST_HALT;
        end else if (dec_taken) begin
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_FLUSH: begin
        state_next = ST_EXEC;
      end
      ST_HALT: begin
        ctrl.s_inc = 1'b0;
        halted     = 1'b1;
        if (resume) begin
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_HALT;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // Retired-instruction counter; bubbles and halt cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= {CNT_W{1'b0}};
    end else if (state == ST_EXEC) begin
      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired <= retired;
    end
  end

  assign s_inc       = ctrl.s_inc;
  assign s_if_return = ctrl.s_if_return;
  assign we3         = ctrl.we3;
  assign wez         = ctrl.wez;
  assign s_we_port   = ctrl.s_we_port;
  assign s_we_stack  = ctrl.s_we_stack;
  assign s_jalret    = ctrl.s_jalret;
  assign op_alu      = ctrl.op_alu;
  assign sel_inputs  = ctrl.sel_inputs;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: decode of every class, jump bubbles,
// HALT/resume, asynchronous reset mid-FLUSH and counter wrap.
module tb_control_unit_fsm;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic             z;
  logic             resume;
  logic             s_inc;
  logic             s_if_return;
  logic             we3;
  logic             wez;
  logic             s_we_port;
  logic             s_we_stack;
  logic             s_jalret;
  logic [2:0]       op_alu;
  logic [1:0]       sel_inputs;
  logic             halted;
  logic [CNT_W-1:0] retired;

  int n_chk  = 0;
  int n_pass = 0;

  control_unit_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .z           (z),
    .resume      (resume),
    .s_inc       (s_inc),
    .s_if_return (s_if_return),
    .we3         (we3),
    .wez         (wez),
    .s_we_port   (s_we_port),
    .s_we_stack  (s_we_stack),
    .s_jalret    (s_jalret),
    .op_alu      (op_alu),
    .sel_inputs  (sel_inputs),
    .halted      (halted),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {s_inc,s_if_return,we3,wez,s_we_port,s_we_stack,s_jalret,op_alu,sel_inputs,halted}
  logic [12:0] outv;
  assign outv = {s_inc, s_if_return, we3, wez, s_we_port, s_we_stack, s_jalret,
                 op_alu, sel_inputs, halted};

  localparam logic [12:0] V_IDLE  = 13'b1_0_0_0_0_0_0_000_00_0;
  localparam logic [12:0] V_STALL = 13'b0_0_0_0_0_0_0_000_00_0;
  localparam logic [12:0] V_HALT  = 13'b0_0_0_0_0_0_0_000_00_1;
  localparam logic [12:0] V_ALU1  = 13'b1_0_1_1_0_0_0_001_00_0;
  localparam logic [12:0] V_ALU7  = 13'b1_0_1_1_0_0_0_111_00_0;
  localparam logic [12:0] V_LI    = 13'b1_0_1_0_0_0_0_000_11_0;
  localparam logic [12:0] V_IN    = 13'b1_0_1_0_0_0_0_000_01_0;
  localparam logic [12:0] V_OUT   = 13'b1_0_0_0_1_0_0_000_00_0;
  localparam logic [12:0] V_JAL   = 13'b0_0_0_0_0_1_1_000_00_0;
  localparam logic [12:0] V_RET   = 13'b0_1_0_0_0_1_0_000_00_0;

  localparam logic [5:0] C_ALU1 = 6'b000100;
  localparam logic [5:0] C_ALU7 = 6'b011111;
  localparam logic [5:0] C_LI   = 6'b100000;
  localparam logic [5:0] C_J    = 6'b110000;
  localparam logic [5:0] C_JZ   = 6'b110001;
  localparam logic [5:0] C_JNZ  = 6'b110010;
  localparam logic [5:0] C_JAL  = 6'b110011;
  localparam logic [5:0] C_RET  = 6'b110100;
  localparam logic [5:0] C_IN   = 6'b110101;
  localparam logic [5:0] C_OUT  = 6'b110110;
  localparam logic [5:0] C_NOP  = 6'b110111;
  localparam logic [5:0] C_HALT = 6'b111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: apply inputs, check strobes mid-cycle, advance one clock.
  task automatic step(input logic [5:0] op, input logic zz, input logic rs,
                      input string tag, input logic [12:0] exp);
    opcode = op;
    z      = zz;
    resume = rs;
    @(negedge clk);
    check(tag, {19'd0, outv}, {19'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = C_NOP;
    z      = 1'b0;
    resume = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // BOOT ignores the opcode on the bus.
    check("cnt_boot", 32'(retired), 32'd0);
    step(C_ALU1, 1'b0, 1'b0, "boot_out", V_IDLE);
    check("cnt_exec0", 32'(retired), 32'd0);

    step(C_ALU1, 1'b0, 1'b0, "alu_op1", V_ALU1);
    check("cnt_alu", 32'(retired), 32'd1);
    step(C_ALU7, 1'b0, 1'b0, "alu_op7", V_ALU7);
    step(C_LI,   1'b0, 1'b0, "li",      V_LI);
    step(C_IN,   1'b0, 1'b0, "in",      V_IN);
    step(C_OUT,  1'b0, 1'b0, "out",     V_OUT);
    step(C_NOP,  1'b1, 1'b0, "nop",     V_IDLE);
    step(C_JZ,   1'b0, 1'b0, "jz_nt",   V_IDLE);
    step(C_JNZ,  1'b1, 1'b0, "jnz_nt",  V_IDLE);
    check("cnt_nt", 32'(retired), 32'd8);

    step(C_JZ,   1'b1, 1'b0, "jz_t",    V_STALL);
    step(C_ALU1, 1'b0, 1'b0, "jz_flush", V_IDLE);
    check("cnt_flush", 32'(retired), 32'd9);
    step(C_JNZ,  1'b0, 1'b0, "jnz_t",   V_STALL);
    step(C_OUT,  1'b0, 1'b0, "jnz_flush", V_IDLE);
    step(C_J,    1'b1, 1'b0, "j",       V_STALL);
    step(C_IN,   1'b0, 1'b0, "j_flush", V_IDLE);
    step(C_JAL,  1'b0, 1'b0, "jal",     V_JAL);
    step(C_JAL,  1'b0, 1'b0, "jal_flush", V_IDLE);
    step(C_RET,  1'b0, 1'b0, "ret",     V_RET);
    step(C_RET,  1'b0, 1'b0, "ret_flush", V_IDLE);
    check("cnt_jumps", 32'(retired), 32'd13);

    step(C_HALT, 1'b0, 1'b0, "halt_instr", V_STALL);
    for (int i = 0; i < 10; i++) begin
      step(C_ALU1, 1'b0, 1'b0, "halt_wait", V_HALT);
    end
    check("cnt_halt", 32'(retired), 32'd14);
    step(C_ALU1, 1'b0, 1'b1, "halt_resume", V_HALT);
    step(C_ALU1, 1'b0, 1'b1, "resume_flush", V_IDLE);
    step(C_ALU1, 1'b0, 1'b0, "after_resume", V_ALU1);
    check("cnt_resume", 32'(retired), 32'd15);

    // Asynchronous reset in the middle of a FLUSH cycle.
    step(C_J, 1'b0, 1'b0, "j_pre_rst", V_STALL);
    opcode = C_JAL;
    #2 reset = 1'b1;
    #1;
    check("rst_async_out", {19'd0, outv}, {19'd0, V_IDLE});
    check("rst_async_cnt", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_out", {19'd0, outv}, {19'd0, V_IDLE});
    reset = 1'b0;
    step(C_JAL, 1'b0, 1'b0, "boot2", V_IDLE);
    step(C_JAL, 1'b0, 1'b0, "exec2_jal", V_JAL);
    step(C_NOP, 1'b0, 1'b0, "exec2_flush", V_IDLE);
    check("cnt_exec2", 32'(retired), 32'd1);

    // Counter wrap: 65534 more NOPs reach all-ones, one more wraps to zero.
    opcode = C_NOP;
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_max", 32'(retired), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    check("cnt_wrap", 32'(retired), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
